// File: rtl/gpio_port_irq.sv
// gpio_port_irq: input synchroniser, per-pin edge detection, interrupt flags,
// priority vector and port interrupt request for one GPIO port.
// The interrupt vector clears on read: a vector read clears the flag it reported.
module gpio_port_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             MCLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] PxIN_raw,
  input  logic [WIDTH-1:0] PxIES,
  input  logic [WIDTH-1:0] PxIE,
  input  logic             PxIFG_wr,
  input  logic [WIDTH-1:0] PxIFG_wdata,
  input  logic             PxIV_rd,
  output logic [WIDTH-1:0] PxIN,
  output logic [WIDTH-1:0] PxIFG,
  output logic [15:0]      PxIV,
  output logic             IRQ
);

  // The arm counter saturates once the synchroniser and prev register have
  // both been refilled with real pin data after reset.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  prev_reg;
  logic [ARM_W-1:0]                  arm_cnt_reg;
  logic [WIDTH-1:0]                  ifg_reg;
  logic [WIDTH-1:0]                  ifg_next;
  logic [WIDTH-1:0]                  edge_det;
  logic [WIDTH-1:0]                  pend;
  logic [WIDTH-1:0]                  clr_mask;
  logic [15:0]                       iv_next;
  logic                              armed;

  assign PxIN  = sync_reg[SYNC_STAGES-1];
  assign armed = (arm_cnt_reg == ARM_W'(ARM_MAX));

  // Synchroniser chain: stage 0 samples the pads, later stages shift along.
  always_ff @(posedge MCLK) begin
    if (!RST_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= PxIN_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  // Previous synchronised value for edge detection, plus the arm counter
  // that keeps the first post-reset transitions from looking like edges.
  always_ff @(posedge MCLK) begin
    if (!RST_n) begin
      prev_reg    <= '0;
      arm_cnt_reg <= '0;
    end else begin
      prev_reg <= PxIN;
      if (!armed) begin
        arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
      end
    end
  end

  // Per-pin edge qualifier: the selected direction only, and only once armed.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_det[gi] = armed &
        ((~prev_reg[gi] &  PxIN[gi] & ~PxIES[gi]) |
         ( prev_reg[gi] & ~PxIN[gi] &  PxIES[gi]));
    end
  endgenerate

  // Priority encode of the enabled pending flags; the lowest index wins and
  // clr_mask marks the single flag that a vector read would clear.
  always_comb begin
    pend     = ifg_reg & PxIE;
    iv_next  = '0;
    clr_mask = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        iv_next     = 16'((i + 1) * 2);
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end
  end

  // Flag next state: software write beats read-clear, and a same-cycle edge
  // always survives either of them.
  always_comb begin
    ifg_next = ifg_reg | edge_det;
    if (PxIFG_wr) begin
      ifg_next = PxIFG_wdata | edge_det;
    end else if (PxIV_rd) begin
      ifg_next = (ifg_reg & ~(clr_mask & ~edge_det)) | edge_det;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge MCLK) begin
    if (!RST_n) begin
      ifg_reg <= '0;
    end else begin
      ifg_reg <= ifg_next;
    end
  end

  assign PxIFG = ifg_reg;
  assign PxIV  = iv_next;
  assign IRQ   = |pend;

endmodule
